// File: rtl/ps2_rx.sv
// PS/2 receive front end: synchronises and deglitches ps2Clk, deserialises 11-bit frames, checks parity/stop.
// Output latency from stop-bit pin fall to valid is FILTER_LEN+4 clk cycles; no backpressure, strobes are one cycle.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] code,
  output logic       valid,
  output logic       error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [1:0]            clk_sync;
  logic [1:0]            dat_sync;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  filt_clk;
  logic                  fall;
  logic                  data_bit;
  logic [3:0]            bit_cnt;
  logic [TW-1:0]         to_cnt;
  logic [7:0]            shreg;
  logic                  par;
  logic                  all_lo;
  logic                  all_hi;

  assign all_lo = ~|filt_sr;
  assign all_hi = &filt_sr;

  // Front end: two-flop synchronisers, level filter and registered falling-edge pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt_sr  <= '1;
      filt_clk <= 1'b1;
      fall     <= 1'b0;
      data_bit <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2Clk};
      dat_sync <= {dat_sync[0], ps2Data};
      filt_sr  <= {filt_sr[FILTER_LEN-2:0], clk_sync[1]};
      if (all_lo)
        filt_clk <= 1'b0;
      else if (all_hi)
        filt_clk <= 1'b1;
      fall <= filt_clk & all_lo;
      if (filt_clk && all_lo)
        data_bit <= dat_sync[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      to_cnt  <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      code    <= 8'h00;
      valid   <= 1'b0;
      error   <= 1'b0;
    end else begin
      valid <= 1'b0;
      error <= 1'b0;
      if (state == IDLE) begin
        to_cnt <= '0;
        if (fall && !data_bit) begin
          state   <= DATA;
          bit_cnt <= '0;
          shreg   <= '0;
        end
      end else if (fall) begin
        // A fall always beats a coincident timeout.
        to_cnt <= '0;
        case (state)
          DATA: begin
            shreg   <= {data_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7)
              state <= PARITY;
          end
          PARITY: begin
            par   <= data_bit;
            state <= STOP;
          end
          default: begin
            if (data_bit && (^{shreg, par})) begin
              code  <= shreg;
              valid <= 1'b1;
            end else begin
              error <= 1'b1;
            end
            state <= IDLE;
          end
        endcase
      end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        error  <= 1'b1;
        state  <= IDLE;
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: frames, parity/stop errors, timeout, glitch rejection and mid-frame reset.
module tb_ps2_rx;

  localparam int FL   = 8;
  localparam int TO   = 5000;
  localparam int HALF = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic [7:0] code;
  logic       valid;
  logic       error;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int n_valid = 0;
  int n_error = 0;
  int n_both = 0;
  int valid_cyc = 0;
  int error_cyc = 0;
  logic [7:0] vq[$];

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2Clk(ps2Clk), .ps2Data(ps2Data),
    .code(code), .valid(valid), .error(error)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      valid_cyc = cyc;
      vq.push_back(code);
    end
    if (error) begin
      n_error++;
      error_cyc = cyc;
    end
    if (valid && error) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      tick(HALF / 2);
      ps2Data = fr[i];
      tick(HALF / 2);
      ps2Clk = 1'b0;
      fall_cyc = cyc;
      tick(HALF);
      ps2Clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] mkf(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  int v0, e0, lat1;

  initial begin
    #5 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ps2Clk  = i[0];
      ps2Data = ~i[1];
      tick(1);
      chk("reset_outputs", {code, valid, error}, 10'h000);
    end
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(1000);
    chk("idle_no_valid", n_valid, 0);
    chk("idle_no_error", n_error, 0);

    // 0x1D: four ones, odd parity bit = 1
    send_bits(mkf(8'h1D, 1'b1, 1'b1), 11);
    tick(20);
    lat1 = valid_cyc - fall_cyc;
    chk("f1d_valid_count", n_valid, 1);
    chk("f1d_code", code, 8'h1D);
    chk("f1d_no_error", n_error, 0);
    chk("f1d_latency_max", lat1 <= FL + 4, 1);
    chk("f1d_latency_min", lat1 >= 1, 1);

    send_bits(mkf(8'hF0, 1'b1, 1'b1), 11);
    send_bits(mkf(8'h1B, 1'b1, 1'b1), 11);
    tick(20);
    chk("b2b_valid_count", n_valid, 3);
    chk("b2b_first", vq[1], 8'hF0);
    chk("b2b_second", vq[2], 8'h1B);
    tick(200);
    chk("b2b_code_hold", code, 8'h1B);
    chk("b2b_no_error", n_error, 0);

    v0 = n_valid;
    send_bits(mkf(8'h44, 1'b0, 1'b1), 11);
    send_bits(mkf(8'h4B, 1'b1, 1'b0), 11);
    tick(20);
    chk("bad_error_count", n_error, 2);
    chk("bad_no_valid", n_valid, v0);
    chk("bad_code_hold", code, 8'h1B);

    e0 = n_error;
    send_bits(mkf(8'h4B, 1'b1, 1'b1), 4);
    tick(TO + 100);
    chk("to_error_count", n_error, e0 + 1);
    chk("to_error_delay", error_cyc - fall_cyc, lat1 + TO);
    chk("to_no_valid", n_valid, v0);
    send_bits(mkf(8'h4B, 1'b1, 1'b1), 11);
    tick(20);
    chk("after_to_valid", n_valid, v0 + 1);
    chk("after_to_code", code, 8'h4B);
    chk("after_to_no_error", n_error, e0 + 1);

    v0 = n_valid;
    e0 = n_error;
    ps2Data = 1'b0;
    tick(2);
    ps2Clk = 1'b0;
    tick(3);
    ps2Clk = 1'b1;
    tick(2);
    ps2Data = 1'b1;
    tick(100);
    chk("glitch_no_valid", n_valid, v0);
    chk("glitch_no_error", n_error, e0);
    send_bits(mkf(8'h1D, 1'b1, 1'b1), 11);
    tick(20);
    chk("glitch_frame_valid", n_valid, v0 + 1);
    chk("glitch_frame_code", code, 8'h1D);
    chk("glitch_frame_no_error", n_error, e0);

    send_bits(mkf(8'h1B, 1'b1, 1'b1), 5);
    rst = 1'b0;
    tick(3);
    chk("midreset_outputs", {code, valid, error}, 10'h000);
    rst = 1'b1;
    tick(10);
    v0 = n_valid;
    e0 = n_error;
    send_bits(mkf(8'h1B, 1'b1, 1'b1), 11);
    tick(20);
    chk("postreset_valid", n_valid, v0 + 1);
    chk("postreset_code", code, 8'h1B);
    chk("postreset_no_error", n_error, e0);

    chk("never_both", n_both, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
